// File: rtl/tof_tbs_tx.sv
// tof_tbs_tx -- serialises a 20-bit echo time-of-flight onto the TBS line.
//
// Frame: HEADER, {4'h0,tof[19:16]}, tof[15:8], tof[7:0] (+ CHK when
// TOF_CHECKSUM_EN is defined; CHK = XOR of the three TOF bytes).
// Each byte is 12 bit-times: start, 8 data bits LSB first, stop, 2 gap.
// A start bit or a data 0 is a short low pulse (PULSE_CNT cycles) at the
// beginning of the bit-time; everything else holds the line high.
//
// Optional feature macro: TOF_CHECKSUM_EN (5-byte frame with checksum).
//
// Ports
//   clk_50M    in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tof_in     in   [19:0] time-of-flight in clk_50M cycles
//   tof_valid  in   tof_in valid this cycle
//   tof_ready  out  block is idle and accepts tof_in
//   TBS_out    out  serial line, idles high (registered)
//   busy       out  a frame is in progress
//   frame_done out  one-cycle pulse in the last cycle of a frame
//
// state | meaning
// IDLE  | line high, waiting for a transfer
// START | start bit of the current byte
// DATA  | data bit bit_idx of the current byte
// STOP  | stop bit
// GAP   | two idle bit-times after the stop bit
module tof_tbs_tx #(
   parameter int          CLK_FREQ  = 50_000_000,
   parameter int          BAUD_RATE = 115200,
   parameter logic [7:0]  HEADER    = 8'hA5
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic [19:0] tof_in,
   input  logic        tof_valid,
   output logic        tof_ready,
   output logic        TBS_out,
   output logic        busy,
   output logic        frame_done
);

   localparam int BIT_CNT   = CLK_FREQ / BAUD_RATE;
   localparam int PULSE_CNT = BIT_CNT / 8;
   localparam int CW        = $clog2(2 * BIT_CNT + 1);

   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(2 * BIT_CNT - 1);
   localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CNT);

`ifdef TOF_CHECKSUM_EN
   localparam logic [2:0] LAST_BYTE = 3'd4;
`else
   localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [2:0]    byte_idx, byte_nx;
   logic [19:0]   tof_q;
   logic [7:0]    cur_byte;
   logic          tbs_nx;
   logic          frame_end;
   logic          take;

   assign tof_ready  = (state == IDLE) && !rst;
   assign busy       = (state != IDLE) && !rst;
   assign frame_done = frame_end && !rst;
   assign take       = tof_valid && tof_ready;

   // Byte selected by the *next* byte index so the registered line value
   // lines up with the first cycle of each bit-time.
   always_comb begin
      cur_byte = HEADER;
      case (byte_nx)
         3'd1:    cur_byte = {4'h0, tof_q[19:16]};
         3'd2:    cur_byte = tof_q[15:8];
         3'd3:    cur_byte = tof_q[7:0];
`ifdef TOF_CHECKSUM_EN
         3'd4:    cur_byte = {4'h0, tof_q[19:16]} ^ tof_q[15:8] ^ tof_q[7:0];
`endif
         default: cur_byte = HEADER;
      endcase
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      bit_nx    = bit_idx;
      byte_nx   = byte_idx;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (take) begin
               state_nx = START;
               bit_nx   = 3'd0;
               byte_nx  = 3'd0;
            end
         end
         START: begin
            if (cnt == BIT_LAST) begin
               state_nx = DATA;
               cnt_nx   = '0;
               bit_nx   = 3'd0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nx = '0;
               if (bit_idx == 3'd7) state_nx = STOP;
               else                 bit_nx   = bit_idx + 3'd1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               state_nx = GAP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               cnt_nx = '0;
               if (byte_idx == LAST_BYTE) begin
                  state_nx  = IDLE;
                  frame_end = 1'b1;
               end else begin
                  state_nx = START;
                  byte_nx  = byte_idx + 3'd1;
               end
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            bit_nx   = 3'd0;
            byte_nx  = 3'd0;
         end
      endcase
      tbs_nx = !(((state_nx == START) ||
                  ((state_nx == DATA) && !cur_byte[bit_nx])) &&
                 (cnt_nx < PULSE_END));
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= 3'd0;
         tof_q    <= '0;
         TBS_out  <= 1'b1;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         bit_idx  <= bit_nx;
         byte_idx <= byte_nx;
         TBS_out  <= tbs_nx;
         if (take) tof_q <= tof_in;
      end
   end

endmodule

// File: tb/tb_tof_tbs_tx.sv
module tb_tof_tbs_tx;

   // 1_000_000 / 9600 = 104 (truncated), 104 / 8 = 13
   localparam int BIT   = 104;
   localparam int PULSE = 13;
`ifdef TOF_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam int FRAME = NB * 12 * BIT;
   localparam int MAXC  = FRAME + 200;

   logic        clk_50M = 1'b0;
   logic        rst;
   logic [19:0] tof_in;
   logic        tof_valid;
   logic        tof_ready;
   logic        TBS_out;
   logic        busy;
   logic        frame_done;

   tof_tbs_tx #(
      .CLK_FREQ  (1_000_000),
      .BAUD_RATE (9600),
      .HEADER    (8'hA5)
   ) dut (
      .clk_50M    (clk_50M),
      .rst        (rst),
      .tof_in     (tof_in),
      .tof_valid  (tof_valid),
      .tof_ready  (tof_ready),
      .TBS_out    (TBS_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk_50M = ~clk_50M;

   typedef struct {
      logic [19:0] tof;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic [7:0]  b3;
      logic [7:0]  chk;
   } vec_t;

   vec_t vecs [4];
   logic s [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Starts a frame with value v and records the line until frame_done.
   // hold keeps tof_valid high and changes tof_in every cycle.
   // abort_at > 0 raises rst at that cycle and returns.
   task automatic run_frame(input logic [19:0] v, input bit hold, input int abort_at,
                            output int done_at);
      int bad;
      bad     = 0;
      done_at = -1;
      @(negedge clk_50M);
      check("ready_before_xfer", 32'(tof_ready), 32'd1);
      tof_in    = v;
      tof_valid = 1'b1;
      s.delete();
      s.push_back(1'b1);
      for (int k = 1; k <= MAXC; k++) begin
         @(negedge clk_50M);
         s.push_back(TBS_out);
         if (busy !== 1'b1 || tof_ready !== 1'b0) bad++;
         if (hold) tof_in = v + 20'(k);
         else      tof_valid = 1'b0;
         if (frame_done === 1'b1) begin
            done_at = k;
            break;
         end
         if (k == abort_at) begin
            rst     = 1'b1;
            done_at = k;
            break;
         end
      end
      check("busy_ready_in_frame", 32'(bad), 32'd0);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] expb [5], input int done_at);
      int   mism, badw, run, p, start, lim;
      logic [7:0] bv, dec;
      check({tag, "_done_at"}, 32'(done_at), 32'(FRAME));
      check({tag, "_first_low"}, 32'(s.size() > 1 ? s[1] : 1'b1), 32'd0);
      mism = 0;
      for (int k = 1; k <= FRAME; k++) begin
         int off, b, w, slot, inb;
         logic low, bitv;
         off  = k - 1;
         b    = off / (12 * BIT);
         w    = off % (12 * BIT);
         slot = w / BIT;
         inb  = w % BIT;
         bv   = expb[b];
         bitv = (slot >= 1 && slot <= 8) ? bv[3'(slot - 1)] : 1'b1;
         low  = (inb < PULSE) && (slot == 0 || !bitv);
         if (k >= s.size()) mism++;
         else if (s[k] !== !low) mism++;
      end
      check({tag, "_waveform"}, 32'(mism), 32'd0);
      lim  = s.size();
      badw = 0;
      run  = 0;
      for (int k = 1; k < lim; k++) begin
         if (s[k] === 1'b0) run++;
         else begin
            if (run != 0 && run != PULSE) badw++;
            run = 0;
         end
      end
      if (run != 0) badw++;
      check({tag, "_pulse_width"}, 32'(badw), 32'd0);
      p = 1;
      for (int b = 0; b < NB; b++) begin
         start = -1;
         for (int k = p; k < lim; k++)
            if (s[k] === 1'b0 && s[k-1] === 1'b1) begin
               start = k;
               break;
            end
         dec = 8'hxx;
         if (start > 0 && start + 8 * BIT < lim) begin
            for (int i = 0; i < 8; i++) dec[i] = (s[start + (i + 1) * BIT] === 1'b0) ? 1'b0 : 1'b1;
            p = start + 10 * BIT;
         end else begin
            p = lim;
         end
         check($sformatf("%s_byte%0d", tag, b), 32'(dec), 32'(expb[b]));
      end
   endtask

   task automatic idle_check(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 3 * BIT; i++) begin
         @(negedge clk_50M);
         if (TBS_out !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
      end
      check({tag, "_idle_after"}, 32'(bad), 32'd0);
   endtask

   initial begin
      logic [7:0] expb [5];
      int d;

      vecs[0] = '{20'h12345, 8'h01, 8'h23, 8'h45, 8'h67};
      vecs[1] = '{20'hFFFFF, 8'h0F, 8'hFF, 8'hFF, 8'h0F};
      vecs[2] = '{20'h00000, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[3] = '{20'hA5C3E, 8'h0A, 8'h5C, 8'h3E, 8'h68};

      rst       = 1'b1;
      tof_valid = 1'b0;
      tof_in    = '0;
      repeat (3) @(negedge clk_50M);
      check("rst_tbs",   32'(TBS_out),    32'd1);
      check("rst_busy",  32'(busy),       32'd0);
      check("rst_done",  32'(frame_done), 32'd0);
      check("rst_ready", 32'(tof_ready),  32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         expb = '{8'hA5, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].chk};
         run_frame(vecs[i].tof, 1'b0, 0, d);
         check_frame($sformatf("vec%0d", i), expb, d);
         idle_check($sformatf("vec%0d", i));
      end

      // valid held through a frame with tof_in changing; back-to-back frames
      expb = '{8'hA5, 8'h06, 8'h78, 8'h9A, 8'hE4};
      run_frame(20'h6789A, 1'b1, 0, d);
      check_frame("hold_first", expb, d);
      expb = '{8'hA5, 8'h00, 8'hBE, 8'hEF, 8'h51};
      run_frame(20'h0BEEF, 1'b0, 0, d);
      check_frame("hold_second", expb, d);
      idle_check("hold_second");

      // one-cycle reset inside a low pulse of the 3rd byte
      run_frame(20'h3C0F1, 1'b0, 2 * 12 * BIT + 3 * BIT + 4, d);
      check("abort_no_early_done", 32'(d), 32'(2 * 12 * BIT + 3 * BIT + 4));
      @(negedge clk_50M);
      check("abort_tbs",   32'(TBS_out),    32'd1);
      check("abort_busy",  32'(busy),       32'd0);
      check("abort_done",  32'(frame_done), 32'd0);
      check("abort_ready", 32'(tof_ready),  32'd0);
      rst = 1'b0;
      expb = '{8'hA5, 8'h0F, 8'h0A, 8'h55, 8'h50};
      run_frame(20'hF0A55, 1'b0, 0, d);
      check_frame("after_abort", expb, d);
      idle_check("after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
